// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 5-stage pipeline main controller.
// Opcodes, control-word bit positions and forwarding selects.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam int CTRL_W = 8;

    localparam int CTRL_RS2_IMM = 7;
    localparam int CTRL_REG_W   = 6;
    localparam int CTRL_MEM_W   = 5;
    localparam int CTRL_MEM_ALU = 4;
    localparam int CTRL_MEM_R   = 3;
    localparam int CTRL_BRANCH  = 2;
    localparam int CTRL_JUMP    = 1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_main_controller_decoder.sv
// Opcode decoder: control word plus operand-usage flags.
// Bit 0 of the control word is reserved and always zero.
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              use1,
    output logic              use2,
    output logic              illegal
);

    always_comb begin
        ctrl    = '0;
        use1    = 1'b0;
        use2    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R:   begin ctrl = 8'b0101_0000; use1 = 1'b1; use2 = 1'b1; end
            OP_I:   begin ctrl = 8'b1101_0000; use1 = 1'b1; end
            OP_S:   begin ctrl = 8'b1010_0000; use1 = 1'b1; use2 = 1'b1; end
            OP_L:   begin ctrl = 8'b1100_1000; use1 = 1'b1; end
            OP_B:   begin ctrl = 8'b0000_0100; use1 = 1'b1; use2 = 1'b1; end
            OP_JAL: ctrl = 8'b0101_0010;
            OP_LUI: ctrl = 8'b1101_0000;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_main_controller.sv
// Main pipeline controller: ID decode, EX/MEM/WB control registers,
// load-use stall, branch flush and EX-stage forwarding selects.
module pipe_main_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RF_ADDR_W = 5,
    parameter bit          HAZARD_EN = 1'b1,
    parameter bit          FWD_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [6:0]           id_opcode,
    input  logic [RF_ADDR_W-1:0] id_rd,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic                 ex_flush,
    output logic                 stall_id,
    output logic                 illegal_op,
    output logic                 ex_valid,
    output logic                 mem_valid,
    output logic                 wb_valid,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [CTRL_W-1:0]    mem_ctrl,
    output logic [CTRL_W-1:0]    wb_ctrl,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic [RF_ADDR_W-1:0] mem_rd,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic [1:0]           ex_fwd_a,
    output logic [1:0]           ex_fwd_b
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic dec_use1, dec_use2, dec_illegal;

    ctrl_decoder u_dec (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .use1    (dec_use1),
        .use2    (dec_use2),
        .illegal (dec_illegal)
    );

    logic                 ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0]    ex_ctrl_q, ex_ctrl_d;
    logic [RF_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [RF_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [RF_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic                 mem_valid_q, mem_valid_d;
    logic [CTRL_W-1:0]    mem_ctrl_q, mem_ctrl_d;
    logic [RF_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [CTRL_W-1:0]    wb_ctrl_q, wb_ctrl_d;
    logic [RF_ADDR_W-1:0] wb_rd_q, wb_rd_d;

    logic hazard;
    logic bubble;

    function automatic logic [1:0] fwd_sel(
        input logic [RF_ADDR_W-1:0] rs,
        input logic                 m_v,
        input logic [CTRL_W-1:0]    m_c,
        input logic [RF_ADDR_W-1:0] m_rd,
        input logic                 w_v,
        input logic [CTRL_W-1:0]    w_c,
        input logic [RF_ADDR_W-1:0] w_rd
    );
        if (m_v && m_c[CTRL_REG_W] && m_rd != '0 && m_rd == rs)
            return FWD_MEM;
        if (w_v && w_c[CTRL_REG_W] && w_rd != '0 && w_rd == rs)
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        hazard = HAZARD_EN && id_valid && ex_valid_q
              && ex_ctrl_q[CTRL_MEM_R] && ex_rd_q != '0
              && ((dec_use1 && ex_rd_q == id_rs1)
               || (dec_use2 && ex_rd_q == id_rs2));
        // Flush wins over stall; either one inserts a bubble into EX.
        bubble     = ex_flush | hazard;
        stall_id   = hazard & ~ex_flush & ~rst;
        illegal_op = id_valid & dec_illegal & ~rst;

        ex_valid_d  = id_valid & ~dec_illegal & ~bubble;
        ex_ctrl_d   = ex_valid_d ? dec_ctrl : '0;
        ex_rd_d     = ex_valid_d ? id_rd : '0;
        ex_rs1_d    = ex_valid_d ? id_rs1 : '0;
        ex_rs2_d    = ex_valid_d ? id_rs2 : '0;
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_rd_d     = mem_rd_q;

        ex_fwd_a = FWD_RF;
        ex_fwd_b = FWD_RF;
        if (FWD_EN && !rst) begin
            ex_fwd_a = fwd_sel(ex_rs1_q, mem_valid_q, mem_ctrl_q, mem_rd_q,
                               wb_valid_q, wb_ctrl_q, wb_rd_q);
            ex_fwd_b = fwd_sel(ex_rs2_q, mem_valid_q, mem_ctrl_q, mem_rd_q,
                               wb_valid_q, wb_ctrl_q, wb_rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign mem_rd    = mem_rd_q;
    assign wb_rd     = wb_rd_q;

endmodule

// File: doc/pipe_main_controller.md
Name: pipe_main_controller

Overview:
- Next-generation main controller for the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode into a control word covering R, I-ALU, load, store, branch, JAL and LUI instructions.
- Carries the control word and register addresses through the EX, MEM and WB pipeline registers.
- Detects load-use hazards (stall), applies branch flush (bubble) and generates EX-stage forwarding selects.

Parameters:
- RF_ADDR_W, 5: register-file address width.
- HAZARD_EN, 1: 1 enables load-use stall generation; 0 ties stall_id low.
- FWD_EN, 1: 1 enables forwarding selects; 0 ties ex_fwd_a and ex_fwd_b to 2'b00.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  instruction bits [6:0].
- id_rd, id_rs1, id_rs2  in  RF_ADDR_W each  register addresses.
- ex_flush  in  1  taken branch/jump resolved in EX; kills the ID instruction.
- stall_id  out  1  hold PC and IF/ID this cycle.
- illegal_op  out  1  ID opcode not in the decode table (combinational).
- ex_valid, mem_valid, wb_valid  out  1 each  stage occupancy.
- ex_ctrl, mem_ctrl, wb_ctrl  out  8 each  control word per stage; zero when the stage is invalid.
- ex_rd, mem_rd, wb_rd  out  RF_ADDR_W each  destination register per stage.
- ex_fwd_a, ex_fwd_b  out  2 each  operand source: 00 register file, 10 MEM result, 01 WB result.

Behaviour:
- Control word bits: [7] rs2_imm_sel (1 selects imm), [6] reg_w_en, [5] mem_w_en, [4] mem_alu_sel (1 selects ALU result), [3] mem_r_en, [2] branch, [1] jump, [0] reserved, always 0.
- Decode table, bits [7:1], for use1 = rs1 used and use2 = rs2 used:
  - 0110011 R: 0101000; use1=1, use2=1.
  - 0010011 I: 1101000; use1=1, use2=0.
  - 0100011 S: 1010000; use1=1, use2=1.
  - 0000011 L: 1100100; use1=1, use2=0.
  - 1100011 B: 0000010; use1=1, use2=1.
  - 1101111 JAL: 0101001; use1=0, use2=0.
  - 0110111 LUI: 1101000; use1=0, use2=0.
  - Any other opcode: all zero; illegal_op = id_valid.
- Decode is combinational from the ID inputs. Each stage register adds one cycle, so ex_* reflects the ID inputs of the previous cycle.
- Load-use stall:
  - stall_id = HAZARD_EN & id_valid & ex_valid & ex_ctrl[3] & (ex_rd != 0) & ((use1 & ex_rd == id_rs1) | (use2 & ex_rd == id_rs2)).
  - While stalled, the EX register loads a bubble (valid=0, ctrl=0). MEM and WB advance normally.
- Flush: when ex_flush = 1, the EX register loads a bubble and stall_id is forced to 0. Flush has priority over stall.
- Normal advance: EX <= decoded ID entry (valid = id_valid & ~illegal_op); MEM <= EX; WB <= MEM every cycle. There is no back-pressure beyond stall_id.
- Forwarding for operand a (operand b is identical, using ex_rs2):
  - 10 if mem_valid & mem_ctrl[6] & mem_rd != 0 & mem_rd == ex_rs1.
  - else 01 if the same condition holds on the WB stage.
  - else 00.
  - MEM has priority over WB. ex_rs1 and ex_rs2 are internal registers captured together with EX.
- rd == x0 never causes a stall or a forward.
- Reset: all valid bits, ctrl words and rd/rs registers go to 0 on the next clock edge.
  - Outputs are 0 from the first edge with rst=1, including when reset is asserted mid-stall or mid-flush.
  - stall_id reads 0 while ex_valid = 0.
- Illegal opcodes are not propagated: the slot enters EX as a bubble, and illegal_op is raised for that cycle only.

Decomposition:
- Package pipe_ctrl_pkg:
  - Opcode localparams: OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_LUI.
  - Control-bit index constants: CTRL_RS2_IMM to CTRL_JUMP.
  - CTRL_W = 8.
  - Forwarding-select constants: FWD_RF, FWD_MEM, FWD_WB.
- One natural sub-module, ctrl_decoder: combinational opcode -> {ctrl, use1, use2, illegal}. It is instantiated once.
- Pipeline registers, hazard logic and forwarding logic live in the top module.

Test Plan:
- Reset then an R-type stream (opcode 0110011, rd=3): ex_ctrl = 0x50 one cycle later, mem_ctrl the next cycle, wb_ctrl the cycle after; all outputs 0 while rst=1.
- Load rd=5 then R-type rs1=5: stall_id = 1 for exactly one cycle, EX holds a bubble (ex_valid=0); the R-type enters EX on the following cycle with ex_fwd_a = 01.
- Load rd=0 then R-type rs1=0: no stall and ex_fwd_a = 00.
- ADDI rd=7, then ADD rs1=7 rs2=7: ex_fwd_a = ex_fwd_b = 10. Inserting one unrelated instruction between them gives 01 instead.
- Load-use condition coincident with ex_flush = 1: stall_id = 0, EX bubble, and the following instruction advances normally.
- Opcode 1111111 with id_valid = 1: illegal_op = 1, ex_valid = 0 next cycle; rst asserted during a stall clears all stages on the next edge.
